// File: rtl/sdpram_fifo_pkg.sv
// Shared defaults and read-latency encodings for the SDPRAM FIFO controller.
package sdpram_fifo_pkg;

    localparam int DEF_ADDR_WIDTH       = 5;
    localparam int DEF_ALMOST_FULL_NUM  = 28;
    localparam int DEF_ALMOST_EMPTY_NUM = 4;

    localparam int OUT_REG_COMB = 0;
    localparam int OUT_REG_REGD = 1;
    localparam int DEF_OUT_REG  = OUT_REG_COMB;

endpackage

// File: rtl/fifo_flag_gen.sv
// Registered FIFO status flags derived from the next-state water level.
module fifo_flag_gen
    import sdpram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
    parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
    input  logic                  wr_clk,
    input  logic                  asyn_rst,
    input  logic [ADDR_WIDTH:0]   level_nxt,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

    always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            full         <= (level_nxt == DEPTH_LVL);
            empty        <= (level_nxt == '0);
            almost_full  <= (level_nxt >= AF_LVL);
            almost_empty <= (level_nxt <= AE_LVL);
        end
    end

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// Pointer/handshake controller for a FIFO built on an external distributed SDPRAM.
module sdpram_fifo_ctrl
    import sdpram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int OUT_REG          = DEF_OUT_REG,
    parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
    parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
    input  logic                  wr_clk,
    input  logic                  asyn_rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  rd_valid,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] wptr, rptr, wptr_nxt, rptr_nxt, level_nxt;
    logic                push, pop;

    // Acceptance looks only at registered flags, so a same-cycle pop never frees a slot for a push.
    assign push = wr_en && !full  && !asyn_rst;
    assign pop  = rd_en && !empty && !asyn_rst;

    always_comb begin
        wptr_nxt  = push ? wptr + PTR_ONE : wptr;
        rptr_nxt  = pop  ? rptr + PTR_ONE : rptr;
        level_nxt = wptr_nxt - rptr_nxt;
    end

    always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            wptr        <= '0;
            rptr        <= '0;
            water_level <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wptr        <= wptr_nxt;
            rptr        <= rptr_nxt;
            water_level <= level_nxt;
            overflow    <= wr_en && full;
            underflow   <= rd_en && empty;
        end
    end

    assign ram_wr_en   = push;
    assign ram_wr_addr = wptr[ADDR_WIDTH-1:0];
    assign ram_rd_addr = rptr[ADDR_WIDTH-1:0];

    generate
        if (OUT_REG == OUT_REG_REGD) begin : g_rd_valid_reg
            always_ff @(posedge wr_clk or posedge asyn_rst) begin
                if (asyn_rst) rd_valid <= 1'b0;
                else          rd_valid <= pop;
            end
        end else begin : g_rd_valid_comb
            assign rd_valid = pop;
        end
    endgenerate

    fifo_flag_gen #(
        .ADDR_WIDTH       (ADDR_WIDTH),
        .ALMOST_FULL_NUM  (ALMOST_FULL_NUM),
        .ALMOST_EMPTY_NUM (ALMOST_EMPTY_NUM)
    ) u_flag_gen (
        .wr_clk       (wr_clk),
        .asyn_rst     (asyn_rst),
        .level_nxt    (level_nxt),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Randomized and directed bench for sdpram_fifo_ctrl against a word-count reference model.
module tb_sdpram_fifo_ctrl;

    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AFN   = 28;
    localparam int AEN   = 4;

    logic wr_clk = 1'b0;
    logic asyn_rst, wr_en, rd_en;

    logic          ram_wr_en0, ram_wr_en1;
    logic [AW-1:0] wa0, ra0, wa1, ra1;
    logic          full0, empty0, af0, ae0, full1, empty1, af1, ae1;
    logic [AW:0]   lvl0, lvl1;
    logic          rdv0, rdv1, ovf0, udf0, ovf1, udf1;

    sdpram_fifo_ctrl #(.ADDR_WIDTH(AW), .OUT_REG(0), .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) dut0 (
        .wr_clk(wr_clk), .asyn_rst(asyn_rst), .wr_en(wr_en), .rd_en(rd_en),
        .ram_wr_en(ram_wr_en0), .ram_wr_addr(wa0), .ram_rd_addr(ra0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .water_level(lvl0), .rd_valid(rdv0), .overflow(ovf0), .underflow(udf0));

    sdpram_fifo_ctrl #(.ADDR_WIDTH(AW), .OUT_REG(1), .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) dut1 (
        .wr_clk(wr_clk), .asyn_rst(asyn_rst), .wr_en(wr_en), .rd_en(rd_en),
        .ram_wr_en(ram_wr_en1), .ram_wr_addr(wa1), .ram_rd_addr(ra1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .water_level(lvl1), .rd_valid(rdv1), .overflow(ovf1), .underflow(udf1));

    always #5 wr_clk = ~wr_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: total words ever written/read; level and addresses follow by arithmetic.
    int unsigned wcnt, rcnt;
    logic        exp_ovf, exp_udf, exp_rdv1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int level();
        return int'(wcnt - rcnt);
    endfunction

    task automatic model_reset();
        wcnt = 0; rcnt = 0;
        exp_ovf = 1'b0; exp_udf = 1'b0; exp_rdv1 = 1'b0;
    endtask

    task automatic check_regs();
        int l;
        l = level();
        check_eq("water_level",   32'(lvl0),  32'(l));
        check_eq("water_level_r", 32'(lvl1),  32'(l));
        check_eq("full",          32'(full0), 32'(l == DEPTH));
        check_eq("empty",         32'(empty0), 32'(l == 0));
        check_eq("almost_full",   32'(af0),   32'(l >= AFN));
        check_eq("almost_empty",  32'(ae0),   32'(l <= AEN));
        check_eq("full_r",        32'(full1), 32'(l == DEPTH));
        check_eq("empty_r",       32'(empty1), 32'(l == 0));
        check_eq("ram_wr_addr",   32'(wa0),   wcnt % DEPTH);
        check_eq("ram_rd_addr",   32'(ra0),   rcnt % DEPTH);
        check_eq("ram_rd_addr_r", 32'(ra1),   rcnt % DEPTH);
        check_eq("overflow",      32'(ovf0),  32'(exp_ovf));
        check_eq("underflow",     32'(udf0),  32'(exp_udf));
        check_eq("overflow_r",    32'(ovf1),  32'(exp_ovf));
        check_eq("underflow_r",   32'(udf1),  32'(exp_udf));
        check_eq("rd_valid_reg",  32'(rdv1),  32'(exp_rdv1));
    endtask

    // Entered at posedge+1; returns at the following posedge+1.
    task automatic cycle(input logic w, input logic r);
        logic acc_w, acc_r;
        wr_en = w;
        rd_en = r;
        acc_w = w && (level() < DEPTH);
        acc_r = r && (level() > 0);
        @(negedge wr_clk);
        check_eq("ram_wr_en",     32'(ram_wr_en0), 32'(acc_w));
        check_eq("ram_wr_en_r",   32'(ram_wr_en1), 32'(acc_w));
        check_eq("rd_valid_comb", 32'(rdv0),       32'(acc_r));
        check_eq("rd_valid_reg_idle", 32'(rdv1),   32'(exp_rdv1));
        @(posedge wr_clk);
        if (acc_w) wcnt++;
        if (acc_r) rcnt++;
        exp_ovf  = w && !acc_w;
        exp_udf  = r && !acc_r;
        exp_rdv1 = acc_r;
        #1;
        check_regs();
    endtask

    initial begin
        asyn_rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_reset();
        repeat (2) @(posedge wr_clk);
        #1;
        check_regs();
        asyn_rst = 1'b0;

        // Fill from empty to full, then push into full.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);

        // Drain, then push+pop at empty.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);

        // Level 10 with simultaneous push/pop.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);

        // Down to level 1, then long push/pop run to wrap the pointers.
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1);

        // Pop at level 3.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // Reset mid-burst at level 17, checked before the next edge.
        while (level() < 17) cycle(1'b1, 1'b0);
        while (level() > 17) cycle(1'b0, 1'b1);
        wr_en = 1'b1;
        rd_en = 1'b1;
        #2;
        asyn_rst = 1'b1;
        #1;
        model_reset();
        check_regs();
        check_eq("ram_wr_en_in_rst", 32'(ram_wr_en0), 32'(0));
        check_eq("rd_valid_in_rst",  32'(rdv0),       32'(0));
        @(posedge wr_clk);
        #1;
        check_regs();
        check_eq("ram_wr_en_in_rst2", 32'(ram_wr_en0), 32'(0));
        asyn_rst = 1'b0;

        // Randomized traffic with shifting push/pop bias to visit full and empty.
        for (int i = 0; i < 3000; i++) begin
            int unsigned pw, pr;
            case ((i / 150) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 25; pr = 75; end
                default: begin pw = 50; pr = 50; end
            endcase
            cycle(logic'($urandom_range(99) < pw), logic'($urandom_range(99) < pr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
